// File: rtl/mul32_iter_pkg.sv
// Shared constants, FSM state type and step-to-shift mapping for the iterative 32x32 multiplier.
// Used by the operand bus, the 16x16 core and the sequencer.
package mul_pkg;

   localparam int W    = 32;
   localparam int HALF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [1:0] step_t;

   // Partial-product weight for each step: lo*lo, hi*lo, lo*hi, hi*hi.
   function automatic int unsigned step_shift(step_t s);
      case (s)
         2'd0:    return 0;
         2'd1:    return 16;
         2'd2:    return 16;
         default: return 32;
      endcase
   endfunction

endpackage

// File: rtl/mul32_iter_if.sv
// Operand/result handshake bus of the iterative multiplier.
// master = producer/consumer side, slave = multiplier side.
interface mul32_iter_if;
   import mul_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   out_data;
   logic             busy;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/mul32_iter_core.sv
// Purely combinational 16x16 unsigned multiplier shared across the four steps.
// Zero latency; no handshake, the sequencer owns all timing.
module mul32_iter_core
   import mul_pkg::*;
(
   input  logic [HALF-1:0] a,
   input  logic [HALF-1:0] b,
   output logic [W-1:0]    p
);

   assign p = {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};

endmodule

// File: rtl/mul32_iter.sv
// 32x32 unsigned multiply over four cycles on one 16x16 core; result 4 edges after capture (0 with zero skip).
// Accepts only in IDLE; the result is held in DONE with out_valid high until out_ready.
module mul32_iter
   import mul_pkg::*;
#(
   parameter bit SKIP_ZERO = 1'b1,
   parameter bit OUT_HOLD  = 1'b1
)
(
   input  logic         clk,
   input  logic         rst_n,
   mul32_iter_if.slave  bus
);

   state_t          state;
   state_t          state_nx;
   step_t           step;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic [2*W-1:0]  acc;
   logic [2*W-1:0]  acc_nx;
   logic [2*W-1:0]  data_r;
   logic [HALF-1:0] core_a;
   logic [HALF-1:0] core_b;
   logic [W-1:0]    pp;
   logic            is_zero;

   assign is_zero = SKIP_ZERO && ((bus.in_a == '0) || (bus.in_b == '0));

   // step[0] selects the high half of a, step[1] the high half of b.
   assign core_a = step[0] ? a_r[W-1:HALF] : a_r[HALF-1:0];
   assign core_b = step[1] ? b_r[W-1:HALF] : b_r[HALF-1:0];

   mul32_iter_core u_core (
      .a (core_a),
      .b (core_b),
      .p (pp)
   );

   assign acc_nx = acc + ({{W{1'b0}}, pp} << step_shift(step));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      bus.out_data  = data_r;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_nx = is_zero ? DONE : MUL;
            end
         end
         MUL: begin
            bus.busy = 1'b1;
            if (step == 2'd3) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step   <= '0;
         a_r    <= '0;
         b_r    <= '0;
         acc    <= '0;
         data_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r  <= bus.in_a;
                  b_r  <= bus.in_b;
                  acc  <= '0;
                  step <= '0;
                  if (is_zero) begin
                     data_r <= '0;
                  end
               end
            end
            MUL: begin
               acc  <= acc_nx;
               step <= step + 2'd1;
               if (step == 2'd3) begin
                  data_r <= acc_nx;
               end
            end
            DONE: begin
               if (bus.out_ready && !OUT_HOLD) begin
                  data_r <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
